// File: rtl/conv_line_buffer_if.sv
// Stream interface of conv_line_buffer: raster pixels in, vertical column vectors out.
interface conv_line_buffer_if #(
  parameter int unsigned COLORDEPTH = 8,
  parameter int unsigned M_DEPTH    = 3
);
  logic [COLORDEPTH-1:0] px_i;
  logic                  dv_i;
  logic                  hs_i;
  logic                  vs_i;
  logic [COLORDEPTH-1:0] vect_o [M_DEPTH-1:0];
  logic                  dv_o;
  logic                  hs_o;
  logic                  vs_o;
  logic                  overflow_o;

  modport master (
    output px_i, dv_i, hs_i, vs_i,
    input  vect_o, dv_o, hs_o, vs_o, overflow_o
  );

  modport slave (
    input  px_i, dv_i, hs_i, vs_i,
    output vect_o, dv_o, hs_o, vs_o, overflow_o
  );
endinterface

// File: rtl/conv_line_buffer.sv
// Line buffer feeding the 3x3 convolution: M_DEPTH-1 rotating line RAMs, 1-cycle column-vector output.
// Optional CONV_LB_EDGE_REPLICATE_EN: pad not-yet-filled rows with the nearest valid row instead of 0.
module conv_line_buffer #(
  parameter int unsigned COLORDEPTH  = 8,
  parameter int unsigned SCREENWIDTH = 1600,
  parameter int unsigned LINE_END    = 2048,
  parameter int unsigned M_DEPTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_line_buffer_if.slave       bus
);
  localparam int unsigned N_RAM = M_DEPTH - 1;
  localparam int unsigned AW    = (LINE_END > 1) ? $clog2(LINE_END) : 1;
  localparam int unsigned SW    = (N_RAM > 1) ? $clog2(N_RAM) : 1;
  localparam int unsigned LW    = $clog2(M_DEPTH);

  typedef logic [COLORDEPTH-1:0] px_t;

  px_t             line_ram [N_RAM][LINE_END];

  logic [AW-1:0]   col_q, col_d;
  logic [SW-1:0]   wr_sel_q, wr_sel_d;
  logic [LW-1:0]   lines_valid_q, lines_valid_d;
  logic            dv_q, dv_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            overflow_q, overflow_d;
  px_t             vect_q [M_DEPTH-1:0];
  px_t             vect_d [M_DEPTH-1:0];
  px_t             row_c  [M_DEPTH-1:0];
  logic            line_end_c;

  // RAM holding the line j lines back: oldest line sits in the RAM about to be overwritten
  function automatic logic [SW-1:0] ram_idx(input logic [SW-1:0] sel, input int unsigned j);
    return SW'((32'(sel) + N_RAM - j) % N_RAM);
  endfunction

  // Raw rows at the current column; RAM reads see the word before this cycle's write
  always_comb begin : rd_rows
    row_c[0] = bus.px_i;
    for (int unsigned j = 1; j < M_DEPTH; j++) begin
      row_c[j] = line_ram[ram_idx(wr_sel_q, j)][col_q];
    end
  end

  always_comb begin : next_state
    px_t pad_c;
    col_d         = col_q;
    wr_sel_d      = wr_sel_q;
    lines_valid_d = lines_valid_q;
    overflow_d    = overflow_q;
    dv_d          = bus.dv_i;
    hs_d          = bus.hs_i;
    vs_d          = bus.vs_i;
    line_end_c    = dv_q & ~bus.dv_i;
`ifdef CONV_LB_EDGE_REPLICATE_EN
    pad_c         = row_c[lines_valid_q];
`else
    pad_c         = '0;
`endif
    for (int unsigned j = 0; j < M_DEPTH; j++) begin
      vect_d[j] = '0;
    end

    if (bus.dv_i) begin
      col_d = col_q + AW'(1);
      if (32'(col_q) >= SCREENWIDTH) begin
        overflow_d = 1'b1;
      end
      for (int unsigned j = 0; j < M_DEPTH; j++) begin
        vect_d[j] = (j <= 32'(lines_valid_q)) ? row_c[j] : pad_c;
      end
    end

    if (line_end_c) begin
      col_d    = '0;
      wr_sel_d = (32'(wr_sel_q) == N_RAM - 1) ? '0 : wr_sel_q + SW'(1);
      if (32'(lines_valid_q) < N_RAM) begin
        lines_valid_d = lines_valid_q + LW'(1);
      end
    end

    // Vertical blank restarts the frame and wins over a coincident line end
    if (!bus.vs_i) begin
      col_d         = '0;
      wr_sel_d      = '0;
      lines_valid_d = '0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      col_q         <= '0;
      wr_sel_q      <= '0;
      lines_valid_q <= '0;
      dv_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      overflow_q    <= 1'b0;
      vect_q        <= '{default: '0};
    end else begin
      col_q         <= col_d;
      wr_sel_q      <= wr_sel_d;
      lines_valid_q <= lines_valid_d;
      dv_q          <= dv_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      overflow_q    <= overflow_d;
      vect_q        <= vect_d;
    end
  end

  // RAM contents are never cleared; stale words are masked by lines_valid
  always_ff @(posedge clk) begin : ram_write
    if (!rst && bus.dv_i) begin
      line_ram[wr_sel_q][col_q] <= bus.px_i;
    end
  end

  assign bus.vect_o     = vect_q;
  assign bus.dv_o       = dv_q;
  assign bus.hs_o       = hs_q;
  assign bus.vs_o       = vs_q;
  assign bus.overflow_o = overflow_q;
endmodule
